pipeline_ctrl: RTL
==================

Name: pipeline_ctrl

Overview:
Parametrised, centralised stall/flush controller for the in-order RISC-V pipeline. It replaces the separate stall and branch-flush logic with one block. The block generalises over:
- pipeline depth;
- the stage where branches resolve;
- load-use latency (multi-bubble).

It adds multi-cycle-unit stalls, a fault drain/halt mode and saturating performance counters. It sits at the CPU top. Its outputs drive the PC write enable and the hold/bubble controls of every pipeline register.

Parameters:
NUM_STAGES, 5, pipeline stages; number of pipeline registers is P = NUM_STAGES-1 (reg 0 = IF/ID ... reg P-1 = MEM/WB).
REG_ADDR_W, 5, register-id width.
REDIRECT_STAGE, 2, index of the stage resolving branches/JALR (2 = EX); range 2..P-1.
LOAD_USE_BUBBLES, 1, bubbles inserted per load-use hazard; range 1..4.
CNT_W, 32, perf-counter width.

Ports:
clk  in  1  clock
reset_n  in  1  reset; one clock; reset is asynchronous and active-low
id_rs1  in  REG_ADDR_W  rs1 of instruction in ID
id_rs2  in  REG_ADDR_W  rs2 of instruction in ID
id_uses_rs1  in  1  ID instruction reads rs1
id_uses_rs2  in  1  ID instruction reads rs2
ex_rd  in  REG_ADDR_W  rd of instruction in EX
ex_mem_read  in  1  EX instruction is a load
ex_busy  in  1  multi-cycle unit in EX not finished
ex_redirect  in  1  mispredict/JALR redirect resolved this cycle
fault  in  1  illegal instr / decompress fail / overflow
resume  in  1  pulse; leave HALT
pc_write  out  1  PC may update
stage_stall  out  P  hold pipeline register i
stage_flush  out  P  load bubble (all-zero) into register i
halted  out  1  state == HALT
stall_cycles  out  CNT_W  RUN cycles with pc_write==0
flush_events  out  CNT_W  accepted redirects

Behaviour:
- State `state_q`: RUN, DRAIN, HALT. Counters `lu_cnt` (0..LOAD_USE_BUBBLES-1) and `drain_cnt` (0..P).
- Reset (async, while reset_n=0):
  - state=RUN; all counters 0.
  - Outputs are gated directly by reset_n: pc_write=0, stage_stall=0, stage_flush=all 1, halted=0.
- Load-use hazard `lu_hit`: ex_mem_read && ex_rd!=0 && ((id_uses_rs1 && id_rs1==ex_rd) || (id_uses_rs2 && id_rs2==ex_rd)).
- RUN: default is pc_write=1, stall=0, flush=0. Priority, highest first:
  1. fault=1: next state DRAIN, drain_cnt<=P-1. The current cycle is treated as normal.
  2. ex_busy=1:
     - pc_write=0; stage_stall[0..REDIRECT_STAGE-2]=1; stage_flush[REDIRECT_STAGE-1]=1.
     - ex_redirect is ignored.
     - lu_cnt holds its value.
  3. ex_redirect=1:
     - pc_write=1; stage_flush[0..REDIRECT_STAGE-2]=1 (wrong-path bubbles).
     - lu_cnt<=0; flush_events+1.
  4. lu_hit or lu_cnt!=0:
     - pc_write=0; stage_stall[0]=1; stage_flush[1]=1.
     - On lu_hit with lu_cnt==0: lu_cnt<=LOAD_USE_BUBBLES-1.
     - On lu_cnt!=0: lu_cnt<=lu_cnt-1 (lu_hit re-check is ignored while counting).
- DRAIN:
  - pc_write=0; stage_flush[0]=1; older registers advance.
  - drain_cnt decrements each cycle; at 0, next state HALT.
  - fault, ex_redirect and lu_hit are ignored; ex_busy still holds the registers behind EX as in RUN.
- HALT:
  - pc_write=0; stage_stall=all 1; flush=0; halted=1.
  - resume=1 moves to RUN next cycle. Nothing else leaves HALT except reset.
- stall_cycles increments in RUN when pc_write==0. Both counters saturate at 2^CNT_W-1 (no wrap).
- All outputs except counters are combinational from inputs and state; they have zero latency.
- stage_stall and stage_flush are never both 1 for the same index.

Decomposition:
- Shared package (common): `pipe_state_t` enum {RUN, DRAIN, HALT}; constant localparams for default stage indices.
- One sub-module, `load_use_detect` (combinational `lu_hit` compare), reused for future dual-issue.
- The counters and FSM stay in pipeline_ctrl.

Test Plan:
- Defaults. Drive ex_mem_read=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 for one cycle → that cycle: pc_write=0, stage_stall=4'b0001, stage_flush=4'b0010. Next cycle: normal. stall_cycles=1.
- LOAD_USE_BUBBLES=3, same stimulus (one cycle) → the stall pattern persists exactly 3 cycles. stall_cycles=3.
- Load with ex_rd=0, id_rs1=0 → no stall. Load hit with id_uses_rs1=0 → no stall.
- Assert ex_busy and ex_redirect together for 2 cycles → stage_stall=4'b0001, stage_flush=4'b0010, flush_events=0. Then busy=0, redirect=1 → stage_flush=4'b0001, pc_write=1, flush_events=1.
- Pulse fault → 4 DRAIN cycles with stage_flush[0]=1, pc_write=0. Then halted=1, stage_stall=4'b1111. Pulse resume → RUN next cycle, pc_write=1.
- Assert reset_n=0 mid-DRAIN asynchronously → outputs take reset values before the next edge; RUN after release. CNT_W=4 with 20 stall cycles → stall_cycles=15.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and default geometry for the pipeline stall/flush controller.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } pipe_state_t;

    localparam int unsigned DEF_NUM_STAGES       = 5;
    localparam int unsigned DEF_REG_ADDR_W       = 5;
    localparam int unsigned DEF_REDIRECT_STAGE   = 2;
    localparam int unsigned DEF_LOAD_USE_BUBBLES = 1;
    localparam int unsigned DEF_CNT_W            = 32;

endpackage

// File: rtl/pipeline_ctrl_load_use_detect.sv
// Combinational load-use hazard compare between the ID source registers and the EX load target.
module load_use_detect
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = DEF_REG_ADDR_W
) (
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    output logic                  lu_hit_c
);

    logic rs1_match;
    logic rs2_match;

    assign rs1_match = id_uses_rs1 && (id_rs1 == ex_rd);
    assign rs2_match = id_uses_rs2 && (id_rs2 == ex_rd);

    // x0 is hard-wired, so a load into it never creates a dependency
    assign lu_hit_c  = ex_mem_read && (ex_rd != '0) && (rs1_match || rs2_match);

endmodule

// File: rtl/pipeline_ctrl.sv
// Centralised stall/flush controller: load-use, multi-cycle, redirect, fault drain/halt
// and saturating performance counters for the in-order pipeline.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned NUM_STAGES       = DEF_NUM_STAGES,
    parameter int unsigned REG_ADDR_W       = DEF_REG_ADDR_W,
    parameter int unsigned REDIRECT_STAGE   = DEF_REDIRECT_STAGE,
    parameter int unsigned LOAD_USE_BUBBLES = DEF_LOAD_USE_BUBBLES,
    parameter int unsigned CNT_W            = DEF_CNT_W
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [REG_ADDR_W-1:0]   id_rs1,
    input  logic [REG_ADDR_W-1:0]   id_rs2,
    input  logic                    id_uses_rs1,
    input  logic                    id_uses_rs2,
    input  logic [REG_ADDR_W-1:0]   ex_rd,
    input  logic                    ex_mem_read,
    input  logic                    ex_busy,
    input  logic                    ex_redirect,
    input  logic                    fault,
    input  logic                    resume,
    output logic                    pc_write,
    output logic [NUM_STAGES-2:0]   stage_stall,
    output logic [NUM_STAGES-2:0]   stage_flush,
    output logic                    halted,
    output logic [CNT_W-1:0]        stall_cycles,
    output logic [CNT_W-1:0]        flush_events
);

    localparam int unsigned P    = NUM_STAGES - 1;
    localparam int unsigned LU_W = $clog2(LOAD_USE_BUBBLES + 1);
    localparam int unsigned DR_W = $clog2(P + 1);

    // Registers younger than the redirect stage, and the register feeding it
    localparam logic [P-1:0] FRONT_MASK = P'((32'd1 << (REDIRECT_STAGE - 1)) - 32'd1);
    localparam logic [P-1:0] BUSY_FLUSH = P'(32'd1 << (REDIRECT_STAGE - 1));
    localparam logic [P-1:0] LU_STALL   = P'(1);
    localparam logic [P-1:0] LU_FLUSH   = P'(2);
    localparam logic [P-1:0] DR_FLUSH   = P'(1);

    pipe_state_t          state_q, state_d;
    logic [LU_W-1:0]      lu_cnt_q, lu_cnt_d;
    logic [DR_W-1:0]      drain_cnt_q, drain_cnt_d;
    logic [CNT_W-1:0]     stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0]     flush_events_q, flush_events_d;

    logic                 lu_hit;
    logic                 core_pc_write;
    logic [P-1:0]         core_stall;
    logic [P-1:0]         core_flush;
    logic                 core_halted;
    logic                 stall_inc;
    logic                 flush_inc;

    load_use_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_load_use_detect (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .lu_hit_c    (lu_hit)
    );

    // Next-state, counter updates and raw control outputs
    always_comb begin
        state_d       = state_q;
        lu_cnt_d      = lu_cnt_q;
        drain_cnt_d   = drain_cnt_q;
        core_pc_write = 1'b0;
        core_stall    = '0;
        core_flush    = '0;
        core_halted   = 1'b0;
        stall_inc     = 1'b0;
        flush_inc     = 1'b0;

        unique case (state_q)
            RUN: begin
                core_pc_write = 1'b1;
                if (fault) begin
                    state_d     = DRAIN;
                    drain_cnt_d = DR_W'(P - 1);
                    lu_cnt_d    = '0;
                end else if (ex_busy) begin
                    core_pc_write = 1'b0;
                    core_stall    = FRONT_MASK;
                    core_flush    = BUSY_FLUSH;
                end else if (ex_redirect) begin
                    core_flush = FRONT_MASK;
                    lu_cnt_d   = '0;
                    flush_inc  = 1'b1;
                end else if (lu_hit || (lu_cnt_q != '0)) begin
                    core_pc_write = 1'b0;
                    core_stall    = LU_STALL;
                    core_flush    = LU_FLUSH;
                    if (lu_cnt_q != '0) begin
                        lu_cnt_d = lu_cnt_q - LU_W'(1);
                    end else begin
                        lu_cnt_d = LU_W'(LOAD_USE_BUBBLES - 1);
                    end
                end
                stall_inc = !core_pc_write;
            end
            DRAIN: begin
                if (ex_busy) begin
                    core_stall = FRONT_MASK;
                    core_flush = BUSY_FLUSH;
                end else begin
                    core_flush = DR_FLUSH;
                end
                if (drain_cnt_q == '0) begin
                    state_d = HALT;
                end else begin
                    drain_cnt_d = drain_cnt_q - DR_W'(1);
                end
            end
            HALT: begin
                core_stall  = '1;
                core_halted = 1'b1;
                if (resume) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase

        stall_cycles_d = stall_cycles_q;
        if (stall_inc && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        end
        flush_events_d = flush_events_q;
        if (flush_inc && (flush_events_q != '1)) begin
            flush_events_d = flush_events_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= RUN;
            lu_cnt_q       <= '0;
            drain_cnt_q    <= '0;
            stall_cycles_q <= '0;
            flush_events_q <= '0;
        end else begin
            state_q        <= state_d;
            lu_cnt_q       <= lu_cnt_d;
            drain_cnt_q    <= drain_cnt_d;
            stall_cycles_q <= stall_cycles_d;
            flush_events_q <= flush_events_d;
        end
    end

    // Reset forces a safe pipeline image without waiting for a clock edge
    assign pc_write     = reset_n && core_pc_write;
    assign stage_stall  = reset_n ? core_stall : '0;
    assign stage_flush  = reset_n ? core_flush : '1;
    assign halted       = reset_n && core_halted;
    assign stall_cycles = stall_cycles_q;
    assign flush_events = flush_events_q;

endmodule
